// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB next-PC predictor, 1-cycle lookup
// Optional macro BPU_UPDATE_BYPASS_EN: same-cycle update forwarded into the lookup.
`ifndef PROC_VALEN
`define PROC_VALEN 32
`endif

module branch_target_predictor #(
    parameter int          ENTRIES   = 64,
    parameter int          TAG_WIDTH = 10,
    parameter logic [1:0]  CNT_RESET = 2'b01
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [`PROC_VALEN-1:0] req_pc_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [`PROC_VALEN-1:0] resp_npc_o,
    output logic                   resp_taken_o,
    input  logic                   upd_valid_i,
    input  logic [`PROC_VALEN-1:0] upd_pc_i,
    input  logic                   upd_taken_i,
    input  logic [`PROC_VALEN-1:0] upd_target_i,
    input  logic                   upd_redirect_i,
    output logic [31:0]            mispredict_cnt_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;
    localparam int TAG_MSB = IDX_W + TAG_WIDTH + 1;

    logic                   r_valid  [ENTRIES];
    logic [1:0]             r_ctr    [ENTRIES];
    logic [TAG_WIDTH-1:0]   r_tag    [ENTRIES];
    logic [`PROC_VALEN-1:0] r_target [ENTRIES];

    logic                   r_resp_valid;
    logic [`PROC_VALEN-1:0] r_resp_npc;
    logic                   r_resp_taken;
    logic [31:0]            r_mispredict_cnt;

    logic [IDX_W-1:0]       w_req_idx;
    logic [TAG_WIDTH-1:0]   w_req_tag;
    logic [IDX_W-1:0]       w_upd_idx;
    logic [TAG_WIDTH-1:0]   w_upd_tag;
    logic                   w_req_fire;
    logic                   w_upd_hit;
    logic                   w_upd_write;
    logic [1:0]             w_new_ctr;
    logic [`PROC_VALEN-1:0] w_new_target;
    logic                   w_lk_hit;
    logic [1:0]             w_lk_ctr;
    logic [`PROC_VALEN-1:0] w_lk_target;
    logic                   w_unused_bits;

    assign w_req_idx = req_pc_i[TAG_LSB-1:2];
    assign w_req_tag = req_pc_i[TAG_MSB:TAG_LSB];
    assign w_upd_idx = upd_pc_i[TAG_LSB-1:2];
    assign w_upd_tag = upd_pc_i[TAG_MSB:TAG_LSB];
    assign w_unused_bits = ^{req_pc_i[`PROC_VALEN-1:TAG_MSB+1], req_pc_i[1:0],
                             upd_pc_i[`PROC_VALEN-1:TAG_MSB+1], upd_pc_i[1:0]};

    // flush wins over a new request so the dropped slot cannot be refilled in the same cycle
    assign req_ready_o = !flush_i && (!r_resp_valid || resp_ready_i);
    assign w_req_fire  = req_valid_i && req_ready_o;

    assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_write = upd_valid_i && (w_upd_hit || upd_taken_i);

    always_comb begin
        w_new_ctr    = 2'b10;
        w_new_target = upd_taken_i ? upd_target_i : r_target[w_upd_idx];
        if (w_upd_hit) begin
            if (upd_taken_i)
                w_new_ctr = (r_ctr[w_upd_idx] == 2'b11) ? 2'b11 : r_ctr[w_upd_idx] + 2'b01;
            else
                w_new_ctr = (r_ctr[w_upd_idx] == 2'b00) ? 2'b00 : r_ctr[w_upd_idx] - 2'b01;
        end
    end

    always_comb begin
        w_lk_hit    = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
        w_lk_ctr    = r_ctr[w_req_idx];
        w_lk_target = r_target[w_req_idx];
`ifdef BPU_UPDATE_BYPASS_EN
        if (w_upd_write && (w_upd_idx == w_req_idx) && (w_upd_tag == w_req_tag)) begin
            w_lk_hit    = 1'b1;
            w_lk_ctr    = w_new_ctr;
            w_lk_target = w_new_target;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CNT_RESET;
            end
        end else if (w_upd_write) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_ctr[w_upd_idx]   <= w_new_ctr;
        end
    end

    // Tags and targets carry no reset; valid guards them
    always_ff @(posedge clk) begin
        if (rst_n && w_upd_write) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= w_new_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid     <= 1'b0;
            r_resp_npc       <= '0;
            r_resp_taken     <= 1'b0;
            r_mispredict_cnt <= '0;
        end else begin
            if (upd_valid_i && upd_redirect_i)
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            if (flush_i) begin
                r_resp_valid <= 1'b0;
            end else if (w_req_fire) begin
                r_resp_valid <= 1'b1;
                if (w_lk_hit && w_lk_ctr[1]) begin
                    r_resp_npc   <= w_lk_target;
                    r_resp_taken <= 1'b1;
                end else begin
                    r_resp_npc   <= req_pc_i + `PROC_VALEN'(4);
                    r_resp_taken <= 1'b0;
                end
            end else if (resp_ready_i) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign resp_valid_o     = r_resp_valid;
    assign resp_npc_o       = r_resp_npc;
    assign resp_taken_o     = r_resp_taken;
    assign mispredict_cnt_o = r_mispredict_cnt;
endmodule
